// File: rtl/dmem_wbuf.sv
// dmem_wbuf: data-memory responder for the MEM-stage load/store port.
// Word-organised single-port RAM (synchronous read) fronted by a posted
// write buffer. Stores are queued and drained into the RAM in cycles with
// no accepted request. Each load returns data one cycle after it is accepted.
//
// Build option: define DMEM_FWD_EN to let a load take its data from the
// youngest matching buffered store when that store has a full byte mask.
// Without it, any load whose word is still buffered stalls until those
// stores have drained.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present
//   req_we     1 = store, 0 = load
//   req_addr   byte address; [1:0] and bits above the word index are ignored
//   req_wdata  store data
//   req_be     store byte enables, be[i] covers wdata[8i+7:8i]
//   req_ready  request accepted when req_valid & req_ready (combinational)
//   resp_valid load data valid (one cycle after the load is accepted)
//   resp_rdata load data, held while resp_valid=0
//   wbuf_empty no stores pending
module dmem_wbuf #(
  parameter int MEM_WORDS  = 256,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        wbuf_empty
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WBUF_DEPTH);

  typedef struct packed {
    logic [AW-1:0] word;
    logic [31:0]   data;
    logic [3:0]    be;
  } wb_entry_t;

  logic [31:0] mem [MEM_WORDS];
  wb_entry_t   wbuf [WBUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_nxt;

  logic [AW-1:0] word;
  logic match, fwd_ok, accept, st_acc, ld_acc, drain;
  wb_entry_t head_e;

  assign word   = req_addr[AW+1:2];
  assign head_e = wbuf[head];

  // Address bits outside the word index are ignored by design.
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_FWD_EN
  logic [3:0]  y_be;
  logic [31:0] y_data;

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    match  = 1'b0;
    y_be   = '0;
    y_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((PW+1)'(i) < count && wbuf[head + PW'(i)].word == word) begin
        match  = 1'b1;
        y_be   = wbuf[head + PW'(i)].be;
        y_data = wbuf[head + PW'(i)].data;
      end
    end
  end

  assign fwd_ok = match & (y_be == 4'hF);
`else
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((PW+1)'(i) < count && wbuf[head + PW'(i)].word == word)
        match = 1'b1;
    end
  end

  assign fwd_ok = 1'b0;
`endif

  assign req_ready = req_we ? (count != FULL_CNT) : (!match || fwd_ok);
  assign accept    = req_valid & req_ready;
  assign st_acc    = accept & req_we;
  assign ld_acc    = accept & ~req_we;
  // A drain only happens when the RAM port is otherwise idle, so a store
  // accept and a drain never coincide.
  assign drain     = ~accept & (count != '0);

  always_comb begin
    count_nxt = count;
    if (st_acc)     count_nxt = count + 1'b1;
    else if (drain) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      wbuf_empty <= 1'b1;
    end else begin
      if (st_acc) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      count      <= count_nxt;
      wbuf_empty <= (count_nxt == '0);
    end
  end

  // Entry storage needs no reset: occupancy is defined by head/count.
  always_ff @(posedge clk) begin
    if (st_acc) wbuf[tail] <= '{word: word, data: req_wdata, be: req_be};
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++)
        if (head_e.be[b]) mem[head_e.word][8*b +: 8] <= head_e.data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= ld_acc;
`ifdef DMEM_FWD_EN
      if (ld_acc) resp_rdata <= fwd_ok ? y_data : mem[word];
`else
      if (ld_acc) resp_rdata <= mem[word];
`endif
    end
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
module tb_dmem_wbuf;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, resp_valid, wbuf_empty;
  logic [31:0] resp_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb [$];
  logic [31:0] last_rd = '0;

  dmem_wbuf #(.MEM_WORDS(256), .WBUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Response monitor: every accepted load must answer exactly one cycle later
  // with the value queued at accept time; rdata must hold otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      last_rd = '0;
    end else if (resp_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got rdata=%h with no load pending", resp_rdata);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (resp_rdata !== e) begin
          miscompares++;
          $display("FAIL load_data: got %h want %h", resp_rdata, e);
        end
      end
      last_rd = resp_rdata;
    end else begin
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL missing_resp: resp_valid=0 want 1 (rdata %h)", sb.pop_front());
      end else if (resp_rdata !== last_rd) begin
        miscompares++;
        $display("FAIL rdata_hold: got %h want %h", resp_rdata, last_rd);
      end
    end
  end

  // Called just after a rising edge. Holds the request until accepted,
  // returns the number of stall cycles seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp, output int stall);
    stall = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    forever begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      stall++;
      if (stall > 20) begin
        vectors++; miscompares++;
        $display("FAIL ready_timeout: addr %h never accepted", addr);
        @(posedge clk); #1 req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (!we) sb.push_back(exp);
    #1 req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
    reset = 1'b1;
    idle(2);
    req_we = 1'b0; req_addr = 32'h10;
    #1 chk("idle_ready_load", 32'(req_ready), 32'd1);
    req_we = 1'b1;
    #1 chk("idle_ready_store", 32'(req_ready), 32'd1);
    chk("idle_wbuf_empty", 32'(wbuf_empty), 32'd1);
    idle(1);
  endtask

  task automatic test_store_load;
    int s;
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, s);
    chk("store_nonempty", 32'(wbuf_empty), 32'd0);
    idle(1);
    chk("drained_empty", 32'(wbuf_empty), 32'd1);
    do_req(0, 32'h10, 0, 0, 32'hDEADBEEF, s);
    chk("load_no_stall", 32'(s), 32'd0);
    idle(2);
  endtask

  task automatic test_full;
    int s;
    for (int i = 0; i < 5; i++) begin
      do_req(1, 32'(i * 4), 32'h100 + 32'(i), 4'hF, 0, s);
      chk($sformatf("full_stall_%0d", i), 32'(s), (i == 4) ? 32'd1 : 32'd0);
    end
    idle(6);
    chk("full_drained", 32'(wbuf_empty), 32'd1);
    do_req(0, 32'h00, 0, 0, 32'h100, s);
    do_req(0, 32'h10, 0, 0, 32'h104, s);
    // Bits above the word index alias onto the same word.
    do_req(0, 32'h0000_0408, 0, 0, 32'h102, s);
    idle(2);
  endtask

  task automatic test_hazard;
    int s;
    do_req(1, 32'h20, 32'h12345678, 4'hF, 0, s);
    do_req(0, 32'h20, 0, 0, 32'h12345678, s);
    chk("hazard_stall", 32'(s), FWD ? 32'd0 : 32'd1);
    idle(4);
    // Older partial, younger full: forwarding may use the youngest.
    do_req(1, 32'h50, 32'h000000AB, 4'h1, 0, s);
    do_req(1, 32'h50, 32'hCAFEF00D, 4'hF, 0, s);
    do_req(0, 32'h50, 0, 0, 32'hCAFEF00D, s);
    chk("young_full_stall", 32'(s), FWD ? 32'd0 : 32'd2);
    idle(4);
  endtask

  task automatic test_merge;
    int s;
    do_req(1, 32'h30, 32'h11223344, 4'hF, 0, s);
    do_req(1, 32'h30, 32'h0000AA00, 4'h2, 0, s);
    idle(3);
    do_req(0, 32'h30, 0, 0, 32'h1122AA44, s);
    idle(1);
    // Youngest match partial: stalls in both builds until both drain.
    do_req(1, 32'h34, 32'h11223344, 4'hF, 0, s);
    do_req(1, 32'h34, 32'h0000AA00, 4'h2, 0, s);
    do_req(0, 32'h34, 0, 0, 32'h1122AA44, s);
    chk("partial_stall", 32'(s), 32'd2);
    idle(2);
    // be=0000 store leaves RAM unchanged.
    do_req(1, 32'h60, 32'h5555AAAA, 4'hF, 0, s);
    do_req(1, 32'h60, 32'hFFFFFFFF, 4'h0, 0, s);
    idle(3);
    chk("be0_drained", 32'(wbuf_empty), 32'd1);
    do_req(0, 32'h60, 0, 0, 32'h5555AAAA, s);
    idle(2);
  endtask

  task automatic test_reset_discard;
    int s;
    do_req(1, 32'h40, 32'h0, 4'hF, 0, s);
    idle(3);
    do_req(1, 32'h40, 32'h99999999, 4'hF, 0, s);
    do_req(1, 32'h44, 32'h44444444, 4'hF, 0, s);
    do_req(1, 32'h48, 32'h48484848, 4'hF, 0, s);
    reset = 1'b0;
    #1;
    chk("midrst_empty", 32'(wbuf_empty), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);
    do_req(0, 32'h40, 0, 0, 32'h0, s);
    chk("post_rst_no_stall", 32'(s), 32'd0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_full();
    test_hazard();
    test_merge();
    test_reset_discard();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
